// File: rtl/mul_div_pkg.sv
// Shared types and constants for the sequential multiplier/divider.
package mul_div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } state_e;

  localparam int unsigned DEF_DIVISOR_LENGTH  = 5;
  localparam int unsigned DEF_DEVIDENT_LENGTH = 2 * DEF_DIVISOR_LENGTH;

  // Width of a counter that must hold 0..iters.
  function automatic int unsigned cnt_width(input int unsigned iters);
    return $clog2(iters + 1);
  endfunction

  localparam int unsigned DEF_CNT_W = cnt_width(DEF_DEVIDENT_LENGTH);

endpackage

// File: rtl/mul_div_step.sv
// One iteration of the datapath: add-shift (multiply) or restoring
// trial-subtract-shift (divide). Purely combinational.
module mul_div_step
  import mul_div_pkg::*;
#(
  parameter int unsigned DIVISOR_LENGTH = DEF_DIVISOR_LENGTH
) (
  input  logic                          div_i,
  input  logic [2*DIVISOR_LENGTH-1:0]   acc_i,
  input  logic [DIVISOR_LENGTH:0]       rem_i,
  input  logic [DIVISOR_LENGTH-1:0]     mcand_i,
  input  logic [DIVISOR_LENGTH-1:0]     divisor_i,
  output logic [2*DIVISOR_LENGTH-1:0]   acc_c_o,
  output logic [DIVISOR_LENGTH:0]       rem_c_o
);

  localparam int unsigned N = DIVISOR_LENGTH;

  logic [N:0]   sum;
  logic [N:0]   shifted;
  logic [N+1:0] trial;
  logic         ge;

  // Multiply: accumulator upper half gets the multiplicand when the
  // multiplier LSB is set, then the whole thing shifts right (carry in).
  // Divide: shift next dividend bit into the partial remainder and keep
  // the trial difference when it is non-negative.
  always_comb begin
    sum     = {1'b0, acc_i[2*N-1:N]};
    if (acc_i[0]) begin
      sum = sum + {1'b0, mcand_i};
    end
    shifted = {rem_i[N-1:0], acc_i[2*N-1]};
    trial   = {1'b0, shifted} - {2'b00, divisor_i};
    ge      = ~trial[N+1];
    if (div_i) begin
      acc_c_o = {acc_i[2*N-2:0], ge};
      rem_c_o = ge ? trial[N:0] : shifted;
    end else begin
      acc_c_o = {sum, acc_i[N-1:1]};
      rem_c_o = rem_i;
    end
  end

endmodule

// File: rtl/seq_multiplier_divider.sv
// Iterative multiplier / restoring divider behind valid/ready ports.
// Optional macro SEQ_MUL_DIV_DIVZERO_FLAG_EN adds the Div_Zero output.
module seq_multiplier_divider
  import mul_div_pkg::*;
#(
  parameter int unsigned DEVIDENT_LENGTH = DEF_DEVIDENT_LENGTH,
  parameter int unsigned DIVISOR_LENGTH  = DEF_DIVISOR_LENGTH
) (
  input  logic                       CLK,
  input  logic                       RST_n,
  input  logic [DEVIDENT_LENGTH-1:0] OperA,
  input  logic [DIVISOR_LENGTH-1:0]  OperB,
  input  logic [DIVISOR_LENGTH-1:0]  OperD,
  input  logic                       Div_nMul,
  input  logic                       In_Valid,
  output logic                       In_Ready,
  output logic                       Out_Valid,
  input  logic                       Out_Ready,
  output logic [DEVIDENT_LENGTH-1:0] Result,
  output logic [DIVISOR_LENGTH-1:0]  Remainder
`ifdef SEQ_MUL_DIV_DIVZERO_FLAG_EN
  ,
  output logic                       Div_Zero
`endif
);

  localparam int unsigned N     = DIVISOR_LENGTH;
  localparam int unsigned W     = DEVIDENT_LENGTH;
  localparam int unsigned CNT_W = cnt_width(W);

  if (W != 2 * N) begin : g_len_check
    $error("DEVIDENT_LENGTH must equal 2*DIVISOR_LENGTH");
  end

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [W-1:0]     acc_q, acc_d;
  logic [N:0]       rem_q, rem_d;
  logic [N-1:0]     mcand_q, mcand_d;
  logic [N-1:0]     divisor_q, divisor_d;
  logic             div_q, div_d;
  logic             dz_q, dz_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic [W-1:0]     result_q, result_d;
  logic [N-1:0]     remainder_q, remainder_d;
  logic [W-1:0]     step_acc;
  logic [N:0]       step_rem;

  mul_div_step #(
    .DIVISOR_LENGTH (N)
  ) u_step (
    .div_i     (div_q),
    .acc_i     (acc_q),
    .rem_i     (rem_q),
    .mcand_i   (mcand_q),
    .divisor_i (divisor_q),
    .acc_c_o   (step_acc),
    .rem_c_o   (step_rem)
  );

  // Next-state, datapath and handshake logic.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    rem_d       = rem_q;
    mcand_d     = mcand_q;
    divisor_d   = divisor_q;
    div_d       = div_q;
    dz_d        = dz_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    result_d    = result_q;
    remainder_d = remainder_q;
    unique case (state_q)
      IDLE: begin
        if (In_Valid && in_ready_q) begin
          in_ready_d = 1'b0;
          cnt_d      = '0;
          rem_d      = '0;
          mcand_d    = OperB;
          divisor_d  = OperD;
          div_d      = Div_nMul;
          dz_d       = Div_nMul && (OperD == '0);
          acc_d      = Div_nMul ? OperA : {{N{1'b0}}, OperD};
          state_d    = Div_nMul ? DIV : MUL;
        end
      end
      MUL: begin
        acc_d = step_acc;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(N - 1)) begin
          state_d     = DONE;
          out_valid_d = 1'b1;
          result_d    = step_acc;
          remainder_d = '0;
          cnt_d       = '0;
        end
      end
      DIV: begin
        if (dz_q) begin
          // Divide by zero short-circuits: saturated quotient, low dividend bits.
          state_d     = DONE;
          out_valid_d = 1'b1;
          result_d    = '1;
          remainder_d = acc_q[N-1:0];
        end else begin
          acc_d = step_acc;
          rem_d = step_rem;
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(W - 1)) begin
            state_d     = DONE;
            out_valid_d = 1'b1;
            result_d    = step_acc;
            remainder_d = step_rem[N-1:0];
            cnt_d       = '0;
          end
        end
      end
      DONE: begin
        if (Out_Ready) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          dz_d        = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset discards any in-flight operation.
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      acc_q       <= '0;
      rem_q       <= '0;
      mcand_q     <= '0;
      divisor_q   <= '0;
      div_q       <= 1'b0;
      dz_q        <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      remainder_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      rem_q       <= rem_d;
      mcand_q     <= mcand_d;
      divisor_q   <= divisor_d;
      div_q       <= div_d;
      dz_q        <= dz_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      remainder_q <= remainder_d;
    end
  end

  assign In_Ready  = in_ready_q;
  assign Out_Valid = out_valid_q;
  assign Result    = result_q;
  assign Remainder = remainder_q;

`ifdef SEQ_MUL_DIV_DIVZERO_FLAG_EN
  logic dz_flag_q, dz_flag_d;

  // Flag is high only while a divide-by-zero result sits in DONE.
  always_comb begin
    dz_flag_d = dz_flag_q;
    if (state_q == DIV && dz_q) begin
      dz_flag_d = 1'b1;
    end else if (state_q == DONE && Out_Ready) begin
      dz_flag_d = 1'b0;
    end
  end

  // Divide-by-zero flag register.
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      dz_flag_q <= 1'b0;
    end else begin
      dz_flag_q <= dz_flag_d;
    end
  end

  assign Div_Zero = dz_flag_q;
`endif

endmodule

// File: doc/seq_multiplier_divider.md
Name: seq_multiplier_divider

Overview:
Iterative, clocked counterpart of the combinational multiplier_divider, with the same operand and result semantics.
- Multiply: shift-add, one bit per cycle.
- Divide: restoring shift-subtract, one bit per cycle.
- Sits behind a valid/ready request port and a valid/ready response port, so a producer issues operations and a consumer drains results.
- Used where area matters more than latency.

Parameters:
- DEVIDENT_LENGTH, 10, dividend and result width; must equal 2*DIVISOR_LENGTH (elaboration-time check).
- DIVISOR_LENGTH, 5, divisor, multiplicand, multiplier and remainder width.

Ports:
- CLK  in  1  clock, rising edge.
- RST_n  in  1  asynchronous active-low reset.
- OperA  in  DEVIDENT_LENGTH  dividend (divide only).
- OperB  in  DIVISOR_LENGTH  multiplicand (multiply only).
- OperD  in  DIVISOR_LENGTH  divisor (divide) or multiplier (multiply).
- Div_nMul  in  1  1 = divide, 0 = multiply.
- In_Valid  in  1  request valid.
- In_Ready  out  1  block can accept a request.
- Out_Valid  out  1  Result/Remainder valid.
- Out_Ready  in  1  consumer accepts the result.
- Result  out  DEVIDENT_LENGTH  quotient or product.
- Remainder  out  DIVISOR_LENGTH  remainder; 0 in multiply mode.

Behaviour:
- Reset: one clock, asynchronous active-low reset on RST_n. Assertion at any time, including mid-operation, forces state IDLE, In_Ready=1, Out_Valid=0, Result=0, Remainder=0, iteration counter=0. Any in-flight operation is discarded.
- States:
  - IDLE: In_Ready=1. On In_Valid&&In_Ready, register OperA/OperB/OperD/Div_nMul and go to MUL or DIV. Operand changes after acceptance are ignored.
  - MUL: DIVISOR_LENGTH iterations. Each cycle, if the current multiplier LSB is 1, add the multiplicand into the upper accumulator half, then shift right. Full 2*DIVISOR_LENGTH product, no truncation.
  - DIV: DEVIDENT_LENGTH iterations, restoring, MSB first. Partial remainder is DIVISOR_LENGTH+1 bits wide; the quotient bit is 1 when the trial subtract is non-negative.
  - DONE: Out_Valid=1; Result/Remainder stable. On Out_Valid&&Out_Ready go to IDLE. In_Ready is 0 in that same cycle and rises the next cycle.
- Latency (acceptance edge to first cycle with Out_Valid=1):
  - Multiply: exactly DIVISOR_LENGTH cycles (5).
  - Divide: exactly DEVIDENT_LENGTH cycles (10).
  - Divide by zero: exactly 1 cycle.
- Divide by zero (OperD==0, Div_nMul=1): no iterations. Result = all ones; Remainder = OperA[DIVISOR_LENGTH-1:0].
- Multiply mode: Remainder=0.
- Backpressure: Out_Valid is held with stable outputs indefinitely while Out_Ready=0. In_Ready stays 0 in MUL, DIV and DONE; there is one operation in flight, no queue.
- Result and Remainder keep their last values after the handshake until the next DONE.
- In_Valid while busy is ignored and not lost-tracked; the producer must hold it until In_Ready.

Optional Feature:
- Macro: SEQ_MUL_DIV_DIVZERO_FLAG_EN.
- Defined: adds output Div_Zero (1 bit). It is 1 while in DONE for a divide-by-zero result, otherwise 0; reset 0.
- Undefined: the port does not exist; divide-by-zero result values are unchanged.

Decomposition:
- Package mul_div_pkg:
  - state enum {IDLE, MUL, DIV, DONE};
  - default length constants;
  - iteration counter width $clog2(DEVIDENT_LENGTH+1).
- Sub-module mul_div_step: combinational single iteration (add-shift or trial-subtract-shift) selected by Div_nMul, instantiated once. FSM, counter and handshake stay in the top.

Test Plan:
- Divide OperA=1023, OperD=15, Out_Ready=1 -> Out_Valid exactly 10 cycles after acceptance; Result=68, Remainder=3; In_Ready=1 one cycle after the handshake.
- Multiply OperB=31, OperD=31 -> Out_Valid after 5 cycles; Result=961, Remainder=0. Also 20*25 -> 500; 31*0 -> 0.
- Divide OperA=25, OperD=0 -> Out_Valid after 1 cycle; Result=1023, Remainder=25; Div_Zero=1 when the macro is defined.
- Backpressure: 25/7 with Out_Ready=0 for 4 cycles -> Result=3, Remainder=4 stable throughout, In_Ready=0. A new In_Valid is not accepted until after the handshake.
- Reset mid-operation: assert RST_n=0 at iteration 6 of 1023/1, asynchronously between edges -> outputs 0 and In_Ready=1 immediately. After release, 21/7 -> Result=3, Remainder=0 with normal latency.
- Back-to-back: 14/2 then 4*3 with In_Valid held high -> results 7 r0 then 12 r0; each accepted on the first cycle In_Ready=1.
